// File: rtl/pipe_flush_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_flush_ctrl
//
// Pipeline control for the IF/ID and ID/EX buffers. Converts taken
// jump/branch resolutions and multi-cycle stall requests from the execute
// stage into a PC redirect strobe, a multi-cycle flush level and a hold level.
// A saturating counter tracks consecutive stall cycles and pulses a timeout
// when a stall runs too long.
//
// Parameters:
//   FLUSH_CYCLES  cycles pipeline_flush_o stays high per accepted jump (1..15)
//   STALL_MAX     consecutive stall count that fires stall_timeout_o (2..255)
//   ADDR_WIDTH    PC / jump target width
//
// Ports:
//   clk               core clock, rising edge
//   rst_n             asynchronous active-low reset
//   jump_flag_i       EX resolved a taken jump/branch this cycle
//   jump_addr_i       jump target, valid with jump_flag_i
//   stall_req_i       EX multi-cycle unit requests a pipeline hold
//   pc_jump_flag_o    registered one-cycle PC redirect strobe
//   pc_jump_addr_o    registered redirect target (holds between jumps)
//   pipeline_flush_o  registered flush level for the IF/ID and ID/EX buffers
//   hold_o            combinational hold for PC and IF/ID
//   stall_cnt_o       registered consecutive-stall count, saturating at 255
//   stall_timeout_o   registered one-cycle pulse when the count hits STALL_MAX
// ----------------------------------------------------------------------------
module pipe_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_MAX    = 64,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_flag_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  stall_req_i,
  output logic                  pc_jump_flag_o,
  output logic [ADDR_WIDTH-1:0] pc_jump_addr_o,
  output logic                  pipeline_flush_o,
  output logic                  hold_o,
  output logic [7:0]            stall_cnt_o,
  output logic                  stall_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [3:0]            FLUSH_LOAD    = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0]            STALL_LIMIT   = 8'(STALL_MAX);
  localparam logic [ADDR_WIDTH-1:0] RST_INST_ADDR = '0;

  // Stall count saturates at all-ones so a very long stall never wraps back
  // through STALL_MAX and re-fires the timeout.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state;
  logic [3:0] flush_cnt;
  logic [7:0] stall_cnt_next;

  assign stall_cnt_next = sat_inc(stall_cnt_o);

  // Requests seen during FLUSH come from instructions being squashed, so they
  // must not hold the front end. A simultaneous jump also squashes the
  // requester, so the jump wins and the hold is dropped.
  assign hold_o = stall_req_i && (state != FLUSH) && !jump_flag_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      flush_cnt        <= 4'd0;
      pc_jump_flag_o   <= 1'b0;
      pc_jump_addr_o   <= RST_INST_ADDR;
      pipeline_flush_o <= 1'b0;
      stall_cnt_o      <= 8'd0;
      stall_timeout_o  <= 1'b0;
    end else begin
      // Strobes default low; only set in the cycle they fire.
      pc_jump_flag_o  <= 1'b0;
      stall_timeout_o <= 1'b0;
      case (state)
        IDLE, STALL: begin
          if (jump_flag_i) begin
            state            <= FLUSH;
            pc_jump_flag_o   <= 1'b1;
            pc_jump_addr_o   <= jump_addr_i;
            pipeline_flush_o <= 1'b1;
            flush_cnt        <= FLUSH_LOAD;
            stall_cnt_o      <= 8'd0;
          end else if (stall_req_i) begin
            // In IDLE the count is zero, so entry lands on 1.
            state           <= STALL;
            stall_cnt_o     <= stall_cnt_next;
            stall_timeout_o <= (stall_cnt_next == STALL_LIMIT) &&
                               (stall_cnt_o != STALL_LIMIT);
          end else begin
            state       <= IDLE;
            stall_cnt_o <= 8'd0;
          end
        end
        FLUSH: begin
          // Flush was raised on entry, so FLUSH_CYCLES-1 more cycles remain.
          if (flush_cnt == 4'd0) begin
            state            <= IDLE;
            pipeline_flush_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state            <= IDLE;
          pipeline_flush_o <= 1'b0;
          stall_cnt_o      <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
module tb_pipe_flush_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        stall_req;

  logic        a_pc_flag, a_flush, a_hold, a_timeout;
  logic [31:0] a_pc_addr;
  logic [7:0]  a_cnt;
  logic        b_pc_flag, b_flush, b_hold, b_timeout;
  logic [31:0] b_pc_addr;
  logic [7:0]  b_cnt;

  int total;
  int passed;

  pipe_flush_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(64), .ADDR_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .stall_req_i(stall_req),
    .pc_jump_flag_o(a_pc_flag), .pc_jump_addr_o(a_pc_addr),
    .pipeline_flush_o(a_flush), .hold_o(a_hold),
    .stall_cnt_o(a_cnt), .stall_timeout_o(a_timeout)
  );

  pipe_flush_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(4), .ADDR_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .stall_req_i(stall_req),
    .pc_jump_flag_o(b_pc_flag), .pc_jump_addr_o(b_pc_addr),
    .pipeline_flush_o(b_flush), .hold_o(b_hold),
    .stall_cnt_o(b_cnt), .stall_timeout_o(b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag, input logic [31:0] addr);
    chk({tag, "_pcflag"}, {31'd0, a_pc_flag}, 32'd0);
    chk({tag, "_addr"}, a_pc_addr, addr);
    chk({tag, "_flush"}, {31'd0, a_flush}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, a_cnt}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, a_timeout}, 32'd0);
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; jump_flag = 1'b0; jump_addr = 32'd0; stall_req = 1'b0;
    step(); step();
    chk_a_idle("rst", 32'd0);
    chk("rst_hold", {31'd0, a_hold}, 32'd0);
    rst_n = 1'b1;

    // Idle five cycles
    repeat (5) step();
    chk_a_idle("idle", 32'd0);
    chk("idle_hold", {31'd0, a_hold}, 32'd0);

    // Jump to 0x100, second jump during flush ignored
    jump_flag = 1'b1; jump_addr = 32'h100;
    step();
    jump_flag = 1'b0;
    chk("j1_pcflag", {31'd0, a_pc_flag}, 32'd1);
    chk("j1_addr", a_pc_addr, 32'h100);
    chk("j1_flush", {31'd0, a_flush}, 32'd1);
    jump_flag = 1'b1; jump_addr = 32'h200; stall_req = 1'b1;
    #1;
    chk("j1_hold_in_flush", {31'd0, a_hold}, 32'd0);
    step();
    jump_flag = 1'b0; stall_req = 1'b0;
    chk("j1_pcflag_c2", {31'd0, a_pc_flag}, 32'd0);
    chk("j1_flush_c2", {31'd0, a_flush}, 32'd1);
    chk("j1_addr_c2", a_pc_addr, 32'h100);
    chk("j1_cnt_c2", {24'd0, a_cnt}, 32'd0);
    step();
    chk_a_idle("j1_end", 32'h100);
    step();
    chk_a_idle("j1_end2", 32'h100);

    // Ten-cycle stall
    stall_req = 1'b1;
    #1;
    chk("s10_hold0", {31'd0, a_hold}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("s10_cnt%0d", i), {24'd0, a_cnt}, i);
      chk($sformatf("s10_tmo%0d", i), {31'd0, a_timeout}, 32'd0);
      chk($sformatf("s10_hold%0d", i), {31'd0, a_hold}, 32'd1);
      chk($sformatf("s10_btmo%0d", i), {31'd0, b_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    stall_req = 1'b0;
    #1;
    chk("s10_hold_off", {31'd0, a_hold}, 32'd0);
    step();
    chk_a_idle("s10_end", 32'h100);

    // STALL_MAX=4 instance, eight-cycle stall
    stall_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("s8_bcnt%0d", i), {24'd0, b_cnt}, i);
      chk($sformatf("s8_btmo%0d", i), {31'd0, b_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    stall_req = 1'b0;
    step();
    chk("s8_bcnt_end", {24'd0, b_cnt}, 32'd0);
    chk("s8_btmo_end", {31'd0, b_timeout}, 32'd0);

    // Simultaneous jump and stall in IDLE
    stall_req = 1'b1; jump_flag = 1'b1; jump_addr = 32'h80;
    #1;
    chk("sim_hold", {31'd0, a_hold}, 32'd0);
    step();
    stall_req = 1'b0; jump_flag = 1'b0;
    chk("sim_pcflag", {31'd0, a_pc_flag}, 32'd1);
    chk("sim_addr", a_pc_addr, 32'h80);
    chk("sim_flush", {31'd0, a_flush}, 32'd1);
    chk("sim_cnt", {24'd0, a_cnt}, 32'd0);
    step();
    chk("sim_flush_c2", {31'd0, a_flush}, 32'd1);
    step();
    chk_a_idle("sim_end", 32'h80);

    // Jump arriving while in STALL with the request still high
    stall_req = 1'b1;
    step(); step();
    chk("sj_cnt2", {24'd0, a_cnt}, 32'd2);
    jump_flag = 1'b1; jump_addr = 32'h300;
    #1;
    chk("sj_hold", {31'd0, a_hold}, 32'd0);
    step();
    jump_flag = 1'b0; stall_req = 1'b0;
    chk("sj_pcflag", {31'd0, a_pc_flag}, 32'd1);
    chk("sj_addr", a_pc_addr, 32'h300);
    chk("sj_cnt", {24'd0, a_cnt}, 32'd0);
    chk("sj_flush", {31'd0, a_flush}, 32'd1);
    step(); step();
    chk_a_idle("sj_end", 32'h300);

    // Reset mid-flush
    jump_flag = 1'b1; jump_addr = 32'h400;
    step();
    jump_flag = 1'b0;
    chk("rf_flush", {31'd0, a_flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_a_idle("rf_async", 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_a_idle("rf_after", 32'd0);

    // Reset mid-stall at count 3
    stall_req = 1'b1;
    step(); step(); step();
    chk("rs_cnt3", {24'd0, a_cnt}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_a_idle("rs_async", 32'd0);
    chk("rs_bcnt", {24'd0, b_cnt}, 32'd0);
    stall_req = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk_a_idle("rs_after", 32'd0);
    chk("rs_btmo", {31'd0, b_timeout}, 32'd0);
    chk("rs_bflush", {31'd0, b_flush}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_flush_ctrl.md
Name: pipe_flush_ctrl

Overview:
- Pipeline control block that generates the flush and hold signals consumed by the IF/ID and ID/EX buffers.
- Takes jump/branch resolution and multi-cycle stall requests from the execute stage.
- Drives the PC redirect, the `pipeline_flush` level for a configurable number of cycles, and `hold`.
- Watches for runaway stalls with a saturating counter.

Parameters:
- `FLUSH_CYCLES`, default 2: cycles `pipeline_flush_o` stays high per accepted jump. Legal range 1..15.
- `STALL_MAX`, default 64: consecutive stall cycles before `stall_timeout_o` pulses. Legal range 2..255.
- `ADDR_WIDTH`, default 32: PC/jump address width (`RV32_ADDR_WIDTH`).

Ports:
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `jump_flag_i` input 1: EX resolved a taken jump/branch this cycle.
- `jump_addr_i` input `ADDR_WIDTH`: target address, valid with `jump_flag_i`.
- `stall_req_i` input 1: EX multi-cycle unit (div/load) requests pipeline hold.
- `pc_jump_flag_o` output 1: one-cycle registered PC redirect strobe.
- `pc_jump_addr_o` output `ADDR_WIDTH`: registered redirect target.
- `pipeline_flush_o` output 1: flush to IF/ID and ID/EX buffers (resets them to NOP).
- `hold_o` output 1: combinational hold for PC and IF/ID.
- `stall_cnt_o` output 8: current consecutive-stall count, saturating.
- `stall_timeout_o` output 1: one-cycle pulse when `stall_cnt_o` reaches `STALL_MAX`.

Behaviour:
- Reset (async, `rst_n`=0), effective immediately and mid-operation:
  - state=IDLE, `pc_jump_flag_o`=0, `pc_jump_addr_o`=0 (`RST_INST_ADDR`).
  - `pipeline_flush_o`=0, `stall_cnt_o`=0, `stall_timeout_o`=0, flush counter=0.
  - Any in-progress flush or stall is abandoned.
- States: IDLE, FLUSH, STALL.
- IDLE:
  - `jump_flag_i`=1 at edge: next cycle `pc_jump_flag_o`=1 for exactly one cycle, `pc_jump_addr_o`=captured `jump_addr_i`. `pipeline_flush_o`=1 starting the same cycle. Flush counter loads `FLUSH_CYCLES`-1. Go to FLUSH.
  - `jump_flag_i`=0 and `stall_req_i`=1: go to STALL, `stall_cnt_o`←1.
- FLUSH:
  - `pipeline_flush_o`=1. Counter decrements each cycle; at 0, next state IDLE and flush drops.
  - Total flush width is exactly `FLUSH_CYCLES` cycles.
  - `jump_flag_i` and `stall_req_i` are ignored; they originate from flushed instructions.
  - `hold_o`=0.
- STALL:
  - `stall_cnt_o` increments each cycle while `stall_req_i`=1, saturating at 255.
  - `stall_timeout_o` pulses for one cycle when the count transitions to `STALL_MAX`. No repeat pulse while the stall persists.
  - `stall_req_i`=0: `stall_cnt_o`←0 next cycle. If `jump_flag_i`=1 in that same cycle, take the IDLE jump path (go to FLUSH); else go to IDLE.
- `hold_o` is combinational: `stall_req_i` & (state≠FLUSH) & ~`jump_flag_i`.
- Simultaneous `jump_flag_i` and `stall_req_i` in IDLE/STALL: jump wins, `hold_o`=0 that cycle, stall request dropped (the requester is flushed).
- `pc_jump_addr_o` holds its last value between jumps. It changes only on an accepted jump.
- Outputs other than `hold_o` are registered; no combinational path from inputs.

Test Plan:
- Reset then idle 5 cycles → all outputs 0, `pc_jump_addr_o`=0x00000000.
- `jump_flag_i`=1, `jump_addr_i`=0x00000100 for 1 cycle (`FLUSH_CYCLES`=2) → next cycle `pc_jump_flag_o`=1, addr=0x100; `pipeline_flush_o` high exactly 2 cycles; second `jump_flag_i` (addr 0x200) during flush ignored, addr stays 0x100.
- `stall_req_i` high 10 cycles → `hold_o` high same 10 cycles; `stall_cnt_o` counts 1..10 then returns 0; no timeout.
- `STALL_MAX`=4, `stall_req_i` held 8 cycles → `stall_timeout_o` single pulse the cycle `stall_cnt_o`=4; count reaches 8.
- `stall_req_i`=1 and `jump_flag_i`=1, addr 0x80, same cycle in IDLE → `hold_o`=0, jump taken, flush asserted, `stall_cnt_o` stays 0.
- `rst_n` pulled low mid-flush (cycle 1 of 2) and mid-stall (count 3) → outputs clear asynchronously; after release, state IDLE, no residual flush or timeout.
